// File: rtl/fp_norm_pkg.sv
// Shared widths, constants and types for the FP adder normalise/round stage.
package fp_norm_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int GRS_W  = 3;
    localparam int FP_W   = 32;
    localparam int WORK_W = MANT_W + GRS_W;

    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_ONE  = 8'h01;
    localparam logic [FP_W-1:0]  POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-2:0] fraction;
    } fp32_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Input (aligned sum) and output (packed result) handshakes of the normalise/round stage.
interface fp_normalize_round_if;
    import fp_norm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exponent;
    logic              in_carry;
    logic [WORK_W-1:0] in_mantissa;
    logic              in_bypass;
    logic [FP_W-1:0]   in_bypass_result;
    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   out_result;
    logic              out_overflow;
    logic              out_underflow;

    modport slave (
        input  in_valid, in_sign, in_exponent, in_carry, in_mantissa,
               in_bypass, in_bypass_result, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport master (
        output in_valid, in_sign, in_exponent, in_carry, in_mantissa,
               in_bypass, in_bypass_result, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised (or subnormal) 27-bit working mantissa and packing.
module fp_round_rne
    import fp_norm_pkg::*;
(
    input  logic              sign_i,
    input  logic [WORK_W-1:0] mant_i,
    input  logic [EXP_W-1:0]  exp_i,
    output fp32_t             result_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic              round_up;
    logic [MANT_W:0]   sig_sum;
    logic [MANT_W-1:0] sig;
    logic [EXP_W:0]    exp_adj;

    always_comb begin
        round_up = mant_i[2] & (mant_i[3] | mant_i[1] | mant_i[0]);
        sig_sum  = {1'b0, mant_i[WORK_W-1:GRS_W]} + {{MANT_W{1'b0}}, round_up};
        sig      = sig_sum[MANT_W-1:0];
        exp_adj  = {1'b0, exp_i};
        if (sig_sum[MANT_W]) begin
            sig     = {1'b1, {(MANT_W-1){1'b0}}};
            exp_adj = {1'b0, exp_i} + {{EXP_W{1'b0}}, 1'b1};
        end

        result_o.sign = sign_i;
        overflow_o    = 1'b0;
        if (sig[MANT_W-1] && (exp_adj >= {1'b0, EXP_MAX})) begin
            result_o.exponent = EXP_MAX;
            result_o.fraction = '0;
            overflow_o        = 1'b1;
        end else begin
            // A carry out of a subnormal sets the hidden bit, so exp_i (==1) becomes the field.
            result_o.exponent = sig[MANT_W-1] ? exp_adj[EXP_W-1:0] : '0;
            result_o.fraction = sig[MANT_W-2:0];
        end
        underflow_o = (result_o.exponent == '0);
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Iterative renormaliser (one left shift per cycle) followed by RNE rounding and IEEE single packing.
module fp_normalize_round
    import fp_norm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fp_normalize_round_if.slave  bus
);

    norm_state_t       state_q;
    logic [WORK_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;
    logic              sign_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [FP_W-1:0]   result_q;
    logic              overflow_q;
    logic              underflow_q;

    logic [EXP_W-1:0]  eff_exp;
    logic [EXP_W:0]    inc_exp;
    logic [WORK_W-1:0] carry_mant;
    fp32_t             rnd_result;
    logic              rnd_overflow;
    logic              rnd_underflow;

    // Exponent 0 on an arithmetic input carries the same weight as exponent 1.
    assign eff_exp    = (bus.in_exponent == '0) ? EXP_ONE : bus.in_exponent;
    assign inc_exp    = {1'b0, eff_exp} + {{EXP_W{1'b0}}, 1'b1};
    assign carry_mant = {1'b1, bus.in_mantissa[WORK_W-1:2],
                         bus.in_mantissa[1] | bus.in_mantissa[0]};

    fp_round_rne u_round (
        .sign_i      (sign_q),
        .mant_i      (mant_q),
        .exp_i       (exp_q),
        .result_o    (rnd_result),
        .overflow_o  (rnd_overflow),
        .underflow_o (rnd_underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= POS_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q  <= 1'b0;
                        sign_q      <= bus.in_sign;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        if (bus.in_bypass) begin
                            result_q    <= bus.in_bypass_result;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (bus.in_carry) begin
                            if (inc_exp >= {1'b0, EXP_MAX}) begin
                                result_q    <= {bus.in_sign, EXP_MAX, {(MANT_W-1){1'b0}}};
                                overflow_q  <= 1'b1;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                mant_q  <= carry_mant;
                                exp_q   <= inc_exp[EXP_W-1:0];
                                state_q <= SHIFT;
                            end
                        end else if (bus.in_mantissa == '0) begin
                            result_q    <= POS_ZERO;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mant_q  <= bus.in_mantissa;
                            exp_q   <= eff_exp;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Stop at exponent 1 without the hidden bit: the value is subnormal.
                    if (mant_q[WORK_W-1] || (exp_q <= EXP_ONE)) begin
                        state_q <= ROUND;
                    end else begin
                        mant_q <= {mant_q[WORK_W-2:0], 1'b0};
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                ROUND: begin
                    result_q    <= rnd_result;
                    overflow_q  <= rnd_overflow;
                    underflow_q <= rnd_underflow;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_overflow  = overflow_q;
    assign bus.out_underflow = underflow_q;

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Consumer end of the adder datapath: accepts the ALU's aligned sum (sign, exponent, carry, mantissa with G/R/S bits) over a valid/ready handshake.
- Renormalises iteratively, one left shift per cycle, then rounds to nearest-even.
- Packs the result into an IEEE-754 single-precision word and presents it on a valid/ready output.
- Sits between the ALU stage and the result register of the FP adder.

Parameters:
- MANT_W, 24, significand width including hidden bit.
- EXP_W, 8, biased exponent width.
- GRS_W, 3, guard/round/sticky bits appended below the significand (fixed at 3).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  aligned result available
- in_ready  output  1  block can accept (high only in IDLE)
- in_sign  input  1  aligned sign
- in_exponent  input  EXP_W  biased exponent; bit 26 of in_mantissa has weight 2^(exp-127)
- in_carry  input  1  carry out of mantissa add
- in_mantissa  input  MANT_W+GRS_W (27)  aligned result, [26:3] significand, [2] G, [1] R, [0] S
- in_bypass  input  1  special-case operand; skip arithmetic
- in_bypass_result  input  32  packed result used when in_bypass=1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  packed IEEE-754 single result
- out_overflow  output  1  result rounded/normalised to infinity
- out_underflow  output  1  result is subnormal, or zero from a nonzero input

Behaviour:
- Reset (synchronous, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_underflow=0, internal mantissa/exponent regs=0.
- Transfers occur on a rising clk edge when valid&&ready. in_exponent==0 on a non-bypass input is treated as 1.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: in_ready=1. On accept:
  - in_bypass=1: out_result=in_bypass_result, flags 0, go to DONE.
  - in_carry=1: mant={1,in_mantissa[26:2]}, new bit0 = in_mantissa[1]|in_mantissa[0] (sticky preserved); exp=in_exponent+1.
    - If exp==255: out_result={in_sign,8'hFF,23'h0}, out_overflow=1, go to DONE.
    - Otherwise go to SHIFT.
  - in_carry=0 and in_mantissa==0: out_result=32'h0000_0000 (+0 regardless of sign), flags 0, go to DONE.
  - Otherwise latch sign, exponent and mantissa; go to SHIFT.
- SHIFT (one action per cycle):
  - mant[26]==1: go to ROUND, no shift.
  - mant[26]==0 and exp>1: mant<<=1 (zero fill), exp-=1, stay in SHIFT.
  - mant[26]==0 and exp==1: subnormal; go to ROUND with subnormal flag set.
- ROUND (RNE):
  - lsb=mant[3], G=mant[2], R=mant[1], S=mant[0]; round_up = G & (lsb|R|S).
  - sig25 = mant[26:3] + round_up.
  - If sig25[24]: significand=1.0, exp+=1. If exp becomes 255: result is infinity, out_overflow=1.
  - Exponent field = sig[23] ? exp : 0, so a rounding carry out of a subnormal yields exponent 1.
  - Fraction = sig[22:0].
  - out_underflow = (exponent field==0).
  - Go to DONE.
- DONE: out_valid=1. out_result and flags are held stable while out_ready=0. On out_valid&&out_ready go to IDLE, and out_valid drops the next cycle.
- No accept in the same cycle as a DONE handoff; in_ready rises the following cycle.
- Latency from accept edge to out_valid:
  - Bypass, zero or carry-overflow paths: 1 cycle.
  - Otherwise: 3 + L cycles, where L = number of shifts performed.
- Reset asserted mid-operation discards the in-flight operand. No partial result appears.

Decomposition:
- Package fp_norm_pkg holds:
  - Width localparams (MANT_W, EXP_W, GRS_W, FP_W=32).
  - EXP_MAX=8'hFF and POS_ZERO.
  - The state enum typedef norm_state_t {IDLE,SHIFT,ROUND,DONE}.
  - Packed struct fp32_t {sign, exponent, fraction}.
- Sub-module fp_round_rne (combinational): mant[26:0] and exp in; packed fields, overflow and underflow out; instantiated in ROUND.

Test Plan:
- 1.0+1.0: carry=1, mant=27'h000_0000, exp=127, sign 0 → out_result 32'h4000_0000, flags 0, out_valid 3 cycles after accept.
- Deep normalise: carry=0, mant=27'h000_0008, exp=127, sign 1 → 23 shifts, out_result 32'hB400_0000, out_valid 26 cycles after accept.
- Tie-to-even, exp=127, sign 0:
  - mant={24'h800001,3'b100} → 32'h3F80_0002.
  - mant={24'h800000,3'b100} → 32'h3F80_0000.
  - mant={24'hFFFFFF,3'b110}, exp=254 → 32'h7F80_0000, out_overflow=1.
- Subnormal: mant=27'h000_0008, exp=10 → 9 shifts then ROUND, out_result 32'h0000_0200, out_underflow=1. Exact cancel: mant=0, sign 1 → 32'h0000_0000.
- Carry overflow and bypass:
  - carry=1, exp=254 → 32'h7F80_0000, out_overflow=1, latency 1.
  - in_bypass=1, in_bypass_result=32'h7FC0_0000 → same word out, latency 1.
- Backpressure/reset:
  - Hold out_ready=0 for 10 cycles → out_result stable, in_ready=0 throughout.
  - Assert reset during SHIFT → next cycle IDLE, in_ready=1, out_valid=0, out_result=0.
